// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, with a
// direct divide-by-zero path. Defining DIV_SIGNED_EN adds the signed_op port.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   prem_step;
    logic             fits;
    logic [WIDTH-1:0] shreg_step;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

`ifdef DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;
    logic q_neg_in, r_neg_in;

    // The core always divides magnitudes; the sign flags are applied on DONE entry.
    always_comb begin
        r_neg_in     = signed_op & dividend[WIDTH-1];
        q_neg_in     = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        dividend_mag = r_neg_in ? (~dividend + WIDTH'(1)) : dividend;
        divisor_mag  = (signed_op & divisor[WIDTH-1]) ? (~divisor + WIDTH'(1)) : divisor;
    end

    always_comb begin
        quo_final = q_neg_q ? (~shreg_step + WIDTH'(1)) : shreg_step;
        rem_final = r_neg_q ? (~prem_step[WIDTH-1:0] + WIDTH'(1)) : prem_step[WIDTH-1:0];
    end
`else
    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        quo_final    = shreg_step;
        rem_final    = prem_step[WIDTH-1:0];
    end
`endif

    // One restoring step: the shift register feeds dividend bits out of its MSB
    // and collects quotient bits into its LSB.
    always_comb begin
        shifted    = (prem_q << 1) | {{WIDTH{1'b0}}, shreg_q[WIDTH-1]};
        fits       = (shifted >= {1'b0, dvsr_q});
        trial      = shifted - {1'b0, dvsr_q};
        prem_step  = fits ? trial : shifted;
        shreg_step = {shreg_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        dvsr_d      = dvsr_q;
        prem_d      = prem_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shreg_d = dividend_mag;
                    dvsr_d  = divisor_mag;
                    prem_d  = '0;
                    count_d = '0;
                    dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    q_neg_d = q_neg_in;
                    r_neg_d = r_neg_in;
`endif
                    if (divisor == '0) begin
                        // Zero divisor skips iteration entirely; remainder is the raw dividend.
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            CALC: begin
                shreg_d = shreg_step;
                prem_d  = prem_step;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d     = DONE;
                    quotient_d  = quo_final;
                    remainder_d = rem_final;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            dvsr_q      <= '0;
            prem_q      <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            dvsr_q      <= dvsr_d;
            prem_q      <= prem_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=8: stimulus pushes expected results,
// an independent monitor checks them whenever done is presented.
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        logic             sop;
        int               due;
        int               busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; start is sampled by the following edge.
    task automatic drive_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sop, input logic [WIDTH-1:0] eq,
                            input logic [WIDTH-1:0] er, input logic edbz);
        exp_t e;
        e.tag         = tag;
        e.q           = eq;
        e.r           = er;
        e.dbz         = edbz;
        e.sop         = sop;
        e.due         = cyc + (edbz ? 1 : WIDTH + 1);
        e.busy_cycles = edbz ? 0 : WIDTH;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        signed_op = sop;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sop, input logic [WIDTH-1:0] eq,
                         input logic [WIDTH-1:0] er, input logic edbz);
        @(posedge clk);
        #1;
        drive_op(tag, a, b, sop, eq, er, edbz);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: compares every done against the oldest expected result.
    initial begin
        exp_t e;
        int   bcnt;
        bcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                bcnt = 0;
            end else if (done) begin
                check("done_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("op %-12s signed=%0b q=0x%0h r=0x%0h dbz=%0b cycle=%0d busy_cycles=%0d",
                             e.tag, e.sop, quotient, remainder, div_by_zero, cyc, bcnt);
                    check({e.tag, "_quotient"}, quotient, e.q);
                    check({e.tag, "_remainder"}, remainder, e.r);
                    check({e.tag, "_dbz"}, div_by_zero, e.dbz);
                    check({e.tag, "_latency"}, cyc, e.due);
                    check({e.tag, "_busy_cycles"}, bcnt, e.busy_cycles);
                    check({e.tag, "_busy_in_done"}, busy, 0);
                end
                bcnt = 0;
            end else if (busy) begin
                bcnt++;
            end
        end
    end

    initial begin
        reset_n  = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        issue("200/7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0);
        drain();
        issue("13/0", 8'd13, 8'd0, 1'b0, 8'hFF, 8'd13, 1'b1);
        drain();

        // Back-to-back: second start is presented during the first op's done cycle.
        issue("5/9", 8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check("b2b_done_seen", done, 1);
        drive_op("255/255", 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0);
        check("b2b_no_idle_gap", busy, 1);
        drain();

        // Start with a zero divisor during CALC cycle 3 must be ignored.
        issue("77/6", 8'd77, 8'd6, 1'b0, 8'd12, 8'd5, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of an operation.
        issue("200/7_abort", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        sb.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_op("100/10", 8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0);
        drain();

        issue("7/7", 8'd7, 8'd7, 1'b0, 8'd1, 8'd0, 1'b0);
        drain();
        issue("3/200", 8'd3, 8'd200, 1'b0, 8'd0, 8'd3, 1'b0);
        drain();
        issue("255/1", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0);
        drain();
        issue("0/5", 8'd0, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0);
        drain();

`ifdef DIV_SIGNED_EN
        issue("s-7/2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0);
        drain();
        issue("s-128/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
        drain();
        issue("s7/-2", 8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
        drain();
        issue("s-9/0", 8'hF7, 8'h00, 1'b1, 8'hFF, 8'hF7, 1'b1);
        drain();
        issue("u249/2", 8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0);
        drain();
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
